// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, widths and helpers for the memory bus arbiter
// Contents:
//   arb_state_e  arbiter FSM states (idle, bus owned by fetch, bus owned by data, response)
//   *_W          bus and counter widths
//   sat_inc      saturating increment used for the data-grant run counter
package mem_arbiter_pkg;

  localparam int INST_ADDR_W = 32;  // fetch address width
  localparam int REG_W       = 32;  // data / register width
  localparam int SEL_W       = 4;   // byte enables
  localparam int RUN_CNT_W   = 8;   // consecutive data-grant counter
  localparam int TO_CNT_W    = 8;   // bus timeout counter

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_e;

  function automatic logic [RUN_CNT_W-1:0] sat_inc(
    input logic [RUN_CNT_W-1:0] value,
    input logic [RUN_CNT_W-1:0] limit
  );
    return (value >= limit) ? value : value + RUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and external bus signals of the memory bus arbiter
// Signals:
//   if_req/if_addr -> if_rdata/if_ack/if_err           instruction-fetch requester
//   mem_req/we/addr/wdata/sel -> mem_rdata/ack/err     data-access requester
//   bus_ce/we/addr/wdata/sel -> bus_rdata/bus_ack      external memory bus
//   stallreq_o                                         stall request toward pipeline control
// Modports: slave = arbiter side, master = environment (requesters + bus) side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                   if_req;
  logic [INST_ADDR_W-1:0] if_addr;
  logic [REG_W-1:0]       if_rdata;
  logic                   if_ack;
  logic                   if_err;

  logic                   mem_req;
  logic                   mem_we;
  logic [REG_W-1:0]       mem_addr;
  logic [REG_W-1:0]       mem_wdata;
  logic [SEL_W-1:0]       mem_sel;
  logic [REG_W-1:0]       mem_rdata;
  logic                   mem_ack;
  logic                   mem_err;

  logic                   bus_ce;
  logic                   bus_we;
  logic [REG_W-1:0]       bus_addr;
  logic [REG_W-1:0]       bus_wdata;
  logic [SEL_W-1:0]       bus_sel;
  logic [REG_W-1:0]       bus_rdata;
  logic                   bus_ack;

  logic                   stallreq_o;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_rdata, bus_ack,
    output if_rdata, if_ack, if_err, mem_rdata, mem_ack, mem_err,
           bus_ce, bus_we, bus_addr, bus_wdata, bus_sel, stallreq_o
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_rdata, bus_ack,
    input  if_rdata, if_ack, if_err, mem_rdata, mem_ack, mem_err,
           bus_ce, bus_we, bus_addr, bus_wdata, bus_sel, stallreq_o
  );

endinterface

// File: rtl/mem_arbiter_timeout_cnt.sv
// rtl/mem_arbiter_timeout_cnt.sv - bus cycle timeout counter with terminal-count flag
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       clear the count (held while the bus is not owned)
//   inc       count one bus cycle
//   tc        current cycle is the LIMIT-th counted cycle
module mem_arbiter_timeout_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [TO_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + TO_CNT_W'(1);
    end
  end

  // Count starts at 0 in the first owned cycle, so LIMIT-1 marks the LIMIT-th cycle.
  assign tc = (count == TO_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between instruction fetch and data access
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset
//   arb   mem_arbiter_if.slave: both requesters, the external bus and stallreq_o
// Parameters:
//   MAX_MEM_RUN  data grants allowed in a row while fetch waits
//   TIMEOUT      owned bus cycles without bus_ack before the access fails
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_MEM_RUN = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave arb
);

  localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(MAX_MEM_RUN);

  arb_state_e           state;
  logic                 owner_mem;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 busy;
  logic                 grant_mem;
  logic                 grant_if;
  logic                 to_tc;

  assign busy = (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);

  // Data access is the older instruction and wins, unless fetch has already
  // watched RUN_LIMIT data grants go by.
  assign grant_mem = arb.mem_req && (!arb.if_req || (run_cnt != RUN_LIMIT));
  assign grant_if  = arb.if_req && !grant_mem;

  assign arb.stallreq_o = (arb.if_req & ~arb.if_ack) | (arb.mem_req & ~arb.mem_ack);

  mem_arbiter_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (!busy),
    .inc (busy),
    .tc  (to_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      owner_mem     <= 1'b0;
      run_cnt       <= '0;
      arb.bus_ce    <= 1'b0;
      arb.bus_we    <= 1'b0;
      arb.bus_addr  <= '0;
      arb.bus_wdata <= '0;
      arb.bus_sel   <= '0;
      arb.if_ack    <= 1'b0;
      arb.if_err    <= 1'b0;
      arb.if_rdata  <= '0;
      arb.mem_ack   <= 1'b0;
      arb.mem_err   <= 1'b0;
      arb.mem_rdata <= '0;
    end else begin
      // Completion flags are single-cycle pulses covering only the RESP state.
      arb.if_ack  <= 1'b0;
      arb.if_err  <= 1'b0;
      arb.mem_ack <= 1'b0;
      arb.mem_err <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (grant_mem) begin
            state         <= ARB_BUSY_MEM;
            owner_mem     <= 1'b1;
            arb.bus_ce    <= 1'b1;
            arb.bus_we    <= arb.mem_we;
            arb.bus_addr  <= arb.mem_addr;
            arb.bus_wdata <= arb.mem_wdata;
            arb.bus_sel   <= arb.mem_sel;
            run_cnt       <= arb.if_req ? sat_inc(run_cnt, RUN_LIMIT) : '0;
          end else if (grant_if) begin
            state         <= ARB_BUSY_IF;
            owner_mem     <= 1'b0;
            arb.bus_ce    <= 1'b1;
            arb.bus_we    <= 1'b0;
            arb.bus_addr  <= arb.if_addr;
            arb.bus_wdata <= '0;
            arb.bus_sel   <= '0;
            run_cnt       <= '0;
          end else begin
            // No grant means if_req is low, so fetch is not being starved.
            run_cnt <= '0;
          end
        end

        ARB_BUSY_IF, ARB_BUSY_MEM: begin
          // An ack arriving in the last allowed cycle still counts as success.
          if (arb.bus_ack || to_tc) begin
            state      <= ARB_RESP;
            arb.bus_ce <= 1'b0;
            if (owner_mem) begin
              arb.mem_ack   <= 1'b1;
              arb.mem_err   <= !arb.bus_ack;
              arb.mem_rdata <= arb.bus_ack ? arb.bus_rdata : '0;
            end else begin
              arb.if_ack   <= 1'b1;
              arb.if_err   <= !arb.bus_ack;
              arb.if_rdata <= arb.bus_ack ? arb.bus_rdata : '0;
            end
          end
        end

        ARB_RESP: begin
          // Requests are not sampled here: the requester is still seeing its ack.
          state <= ARB_IDLE;
        end

        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port bus arbiter that shares one external memory bus between the instruction-fetch path and the data-access (MEM stage) path of the five-stage core. It serialises requests, favours the data access (older instruction) with a bounded-starvation guarantee for fetch, and detects bus timeouts. It raises a stall request toward the pipeline controller while any requester is waiting.

## Interface
- `MAX_MEM_RUN`, default 4: consecutive MEM grants allowed while IF waits before IF is forced a grant.
- `TIMEOUT`, default 255: BUSY cycles without `bus_ack` before the access is aborted with error (8-bit counter).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  32  fetch address (`InstAddrBus`).
- `if_rdata`  out  32  fetched instruction; valid while `if_ack`.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_err`  out  1  qualifies `if_ack`: access timed out.
- `mem_req`  in  1  data request; held until `mem_ack`.
- `mem_we`  in  1  1 = write.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  write data (`RegBus`).
- `mem_sel`  in  4  byte enables.
- `mem_rdata`  out  32  read data; valid while `mem_ack`.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  qualifies `mem_ack`: timeout.
- `bus_ce`  out  1  bus cycle active.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel`  out  1/32/32/4  bus command, registered.
- `bus_rdata`  in  32  bus read data, sampled on `bus_ack`.
- `bus_ack`  in  1  bus completion, 1 cycle.
- `stallreq_o`  out  1  `(if_req & ~if_ack) | (mem_req & ~mem_ack)`, combinational.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE: both requests → MEM wins unless `run_cnt == MAX_MEM_RUN`, then IF. Single request → that one. None → stay. Winner's command latched into `bus_*` registers; `bus_ce` set; owner flag recorded.
- `run_cnt`: +1 on MEM grant while `if_req` high (saturating); cleared on any IF grant or when `if_req` low in IDLE.
- BUSY_x: `bus_ce` held, command stable. On `bus_ack`: latch `bus_rdata` into owner's rdata register, clear `bus_ce`, → RESP. Timeout counter increments each BUSY cycle; on reaching `TIMEOUT` without ack: clear `bus_ce`, rdata = 0, set err, → RESP.
- RESP: owner's `ack` (and `err` if timed out) high exactly this cycle; no requests sampled; → IDLE. Requester drops or changes `req` on the cycle after `ack`.
- Non-owner `ack`/`err` always 0. `rdata` holds last value outside `ack`.
- `bus_ack` in IDLE or RESP is ignored.
- Writes: `mem_rdata` on write completion is don't-care; `bus_wdata`/`bus_sel` are 0 during IF accesses, `bus_we` = 0.

## Timing
- Reset: state IDLE; `bus_ce`, `bus_we`, `if_ack`, `mem_ack`, `if_err`, `mem_err` = 0; `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata` = 0; `bus_sel` = 0; `run_cnt`, timeout counter = 0.
- Request at cycle N (IDLE) → `bus_ce` at N+1 → `bus_ack` earliest N+1 → `ack` at N+2 → IDLE at N+3. Minimum 3 cycles per access.
- Timeout: `bus_ce` high for exactly `TIMEOUT` cycles, then `ack` + `err` next cycle.
- `bus_ack` coincident with timeout limit: treated as success (err = 0).
- Reset mid-access: next edge forces IDLE, `bus_ce` = 0, no `ack` issued; pending request re-arbitrated after reset release.

## Structure
- `defines.v`: state encodings (`ArbIdle`, `ArbBusyIf`, `ArbBusyMem`, `ArbResp`), reuse `InstAddrBus`, `RegBus`, `RstEnable`.
- One natural sub-module: `arb_timeout_cnt` (load/clear, increment, terminal-count flag).

## Test plan
- IF only, bus_ack 2 cycles after `bus_ce`, data 0x3C010101 → `if_ack` one cycle with `if_rdata` = 0x3C010101, `if_err` = 0, 4 cycles total.
- IF and MEM simultaneous, MEM write addr 0x100, data 0xDEADBEEF, sel 0xF → MEM granted first, `bus_we` = 1; IF granted after `mem_ack`.
- MEM held continuously with IF waiting, `MAX_MEM_RUN` = 4 → 4 MEM accesses, then 1 IF access, then MEM resumes.
- No `bus_ack`, `TIMEOUT` = 255 → `bus_ce` high 255 cycles, then `mem_ack` = `mem_err` = 1, `mem_rdata` = 0.
- `rst` asserted while BUSY_IF → `bus_ce` = 0 next cycle, no `if_ack`; late `bus_ack` ignored; `stallreq_o` tracks `if_req`.
